// File: rtl/seg7_capture_if.sv
// Change-event channel of seg7_capture: valid/ready handshake carrying digit index, value and kind.
// With SEG7_CAPTURE_DP_EN defined the channel also carries the decimal point (evt_dp).
interface seg7_capture_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_digit;
    logic [3:0] evt_value;
    logic [1:0] evt_kind;
`ifdef SEG7_CAPTURE_DP_EN
    logic       evt_dp;

    modport master (output evt_valid, evt_digit, evt_value, evt_kind, evt_dp, input evt_ready);
    modport slave  (input evt_valid, evt_digit, evt_value, evt_kind, evt_dp, output evt_ready);
`else
    modport master (output evt_valid, evt_digit, evt_value, evt_kind, input evt_ready);
    modport slave  (input evt_valid, evt_digit, evt_value, evt_kind, output evt_ready);
`endif
endinterface

// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed 7-segment bus, debounces each position and reports changes.
// Optional decimal-point capture is enabled with the macro SEG7_CAPTURE_DP_EN.
module seg7_capture #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_CAPTURE_DP_EN
    input  logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   dps,
`endif
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [2*NUM_DIGITS-1:0] kinds,
    output logic [NUM_DIGITS-1:0]   dvalid,
    output logic                    sel_err,
    seg7_capture_if.master          evt
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_CAPTURE_DP_EN
    localparam int PW = 8;
`else
    localparam int PW = 7;
`endif

    typedef enum logic [1:0] {
        KIND_BLANK = 2'b00,
        KIND_HEX   = 2'b01,
        KIND_DASH  = 2'b10,
        KIND_INV   = 2'b11
    } kind_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Returns {kind, value} for a g..a segment pattern.
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b0111111: return {KIND_HEX, 4'h0};
            7'b0000110: return {KIND_HEX, 4'h1};
            7'b1011011: return {KIND_HEX, 4'h2};
            7'b1001111: return {KIND_HEX, 4'h3};
            7'b1100110: return {KIND_HEX, 4'h4};
            7'b1101101: return {KIND_HEX, 4'h5};
            7'b1111101: return {KIND_HEX, 4'h6};
            7'b0000111: return {KIND_HEX, 4'h7};
            7'b1111111: return {KIND_HEX, 4'h8};
            7'b1101111: return {KIND_HEX, 4'h9};
            7'b1110111: return {KIND_HEX, 4'hA};
            7'b1111100: return {KIND_HEX, 4'hB};
            7'b0111001: return {KIND_HEX, 4'hC};
            7'b1011110: return {KIND_HEX, 4'hD};
            7'b1111001: return {KIND_HEX, 4'hE};
            7'b1110001: return {KIND_HEX, 4'hF};
            7'b1000000: return {KIND_DASH, 4'h0};
            7'b0000000: return {KIND_BLANK, 4'h0};
            default:    return {KIND_INV, 4'h0};
        endcase
    endfunction

    logic [PW-1:0]         pat;
    logic [PW-1:0]         cand   [NUM_DIGITS];
    logic [CW-1:0]         cnt    [NUM_DIGITS];
    logic [3:0]            val_q  [NUM_DIGITS];
    logic [1:0]            kind_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] dvalid_q;
    logic [NUM_DIGITS-1:0] dirty;
    logic [NUM_DIGITS-1:0] dirty_next;
    logic                  sel_err_q;

    logic [IW-1:0]         sel_idx;
    logic                  hit;
    logic                  match;
    logic                  saturated;
    logic [CW-1:0]         cnt_next;
    logic                  commit;
    logic [5:0]            dec;
    logic                  changed;

    state_e                state_q;
    state_e                state_next;
    logic                  launch;
    logic [IW-1:0]         pick;

`ifdef SEG7_CAPTURE_DP_EN
    assign pat = {seg_dp, seg};
`else
    assign pat = seg;
`endif

    // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) sel_idx = IW'(i);
        end
    end

    assign hit       = sample && $onehot(dig_sel);
    assign match     = (pat == cand[sel_idx]);
    assign saturated = (cnt[sel_idx] == CW'(STABLE_CNT));
    assign cnt_next  = !match ? CW'(1) : (saturated ? cnt[sel_idx] : cnt[sel_idx] + CW'(1));
    assign commit    = hit && (cnt_next == CW'(STABLE_CNT)) && !(match && saturated);
    assign dec       = decode(seg);

`ifdef SEG7_CAPTURE_DP_EN
    assign changed = !dvalid_q[sel_idx] || ({kind_q[sel_idx], val_q[sel_idx]} != dec)
                     || (dp_q[sel_idx] != seg_dp);
`else
    assign changed = !dvalid_q[sel_idx] || ({kind_q[sel_idx], val_q[sel_idx]} != dec);
`endif

    always_comb begin
        pick = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            if (dirty[j]) pick = IW'(j);
        end
    end

    // A change committed in the launch cycle must survive the launch clear.
    always_comb begin
        dirty_next = dirty;
        if (launch) dirty_next[pick] = 1'b0;
        if (commit && changed) dirty_next[sel_idx] = 1'b1;
    end

    // NOTE: the per-digit arrays are reset explicitly; the bench and consumers rely on a clean start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i]   <= '0;
                cnt[i]    <= '0;
                val_q[i]  <= '0;
                kind_q[i] <= '0;
            end
            dp_q      <= '0;
            dvalid_q  <= '0;
            dirty     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            dirty <= dirty_next;
            if (sample && !$onehot(dig_sel)) sel_err_q <= 1'b1;
            if (hit) begin
                cand[sel_idx] <= pat;
                cnt[sel_idx]  <= cnt_next;
            end
            if (commit) begin
                val_q[sel_idx]    <= dec[3:0];
                kind_q[sel_idx]   <= dec[5:4];
                dp_q[sel_idx]     <= pat[PW-1] & (PW == 8);
                dvalid_q[sel_idx] <= 1'b1;
            end
        end
    end

    // Event arbiter: state register, next-state logic, output logic.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:  if (|dirty) state_next = S_SEND;
            S_SEND:  if (evt.evt_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        launch        = (state_q == S_IDLE) && (|dirty);
        evt.evt_valid = (state_q == S_SEND);
    end

    // Payload snapshots the committed registers before this edge's commit lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt.evt_digit <= '0;
            evt.evt_value <= '0;
            evt.evt_kind  <= '0;
`ifdef SEG7_CAPTURE_DP_EN
            evt.evt_dp    <= 1'b0;
`endif
        end else if (launch) begin
            evt.evt_digit <= 3'(pick);
            evt.evt_value <= val_q[pick];
            evt.evt_kind  <= kind_q[pick];
`ifdef SEG7_CAPTURE_DP_EN
            evt.evt_dp    <= dp_q[pick];
`endif
        end
    end

    always_comb begin
        digits = '0;
        kinds  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[4*i +: 4] = val_q[i];
            kinds[2*i +: 2]  = kind_q[i];
        end
    end

    assign dvalid  = dvalid_q;
    assign sel_err = sel_err_q;
`ifdef SEG7_CAPTURE_DP_EN
    assign dps     = dp_q;
`endif

endmodule
